// File: rtl/cordic_arbiter.sv
// Round-robin arbiter sharing one fully pipelined CORDIC cosine unit between
// two requesters. A valid/id/tag pipeline shadows the unit's latency, so every
// result is routed back to the requester that issued it, along with its tag.
// Per-requester outstanding counters stop either side from flooding the unit.
module cordic_arbiter #(
  parameter int LATENCY = 33,
  parameter int TAG_W   = 4,
  parameter int MAX_OUT = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_theta,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_theta,
  input  logic [TAG_W-1:0] req1_tag,
  output logic [31:0]      cordic_theta,
  input  logic [31:0]      cordic_result,
  output logic             rsp0_valid,
  output logic [31:0]      rsp0_result,
  output logic [TAG_W-1:0] rsp0_tag,
  output logic             rsp1_valid,
  output logic [31:0]      rsp1_result,
  output logic [TAG_W-1:0] rsp1_tag,
  output logic             busy
);

  // One tracking stage per cycle between the accepting edge and the edge at
  // which the output registers sample the unit's result.
  localparam int DEPTH = LATENCY + 1;
  localparam int CNT_W = $clog2(MAX_OUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] out_cnt_0;
  logic [CNT_W-1:0] out_cnt_1;
  logic             last_grant;
  logic             elig_0;
  logic             elig_1;
  logic             grant_0;
  logic             grant_1;
  logic             accept;
  logic [DEPTH-1:0] trk_valid;
  logic [DEPTH-1:0] trk_id;
  logic [TAG_W-1:0] trk_tag [DEPTH];

  assign elig_0 = req0_valid && (out_cnt_0 < CNT_MAX);
  assign elig_1 = req1_valid && (out_cnt_1 < CNT_MAX);

  // Grant a lone eligible requester; on contention favour the one not granted last
  always_comb begin
    grant_0 = 1'b0;
    grant_1 = 1'b0;
    if (elig_0 && elig_1) begin
      if (last_grant) grant_0 = 1'b1;
      else            grant_1 = 1'b1;
    end else if (elig_0) begin
      grant_0 = 1'b1;
    end else if (elig_1) begin
      grant_1 = 1'b1;
    end
  end

  assign accept     = grant_0 | grant_1;
  assign req0_ready = grant_0;
  assign req1_ready = grant_1;

  // Steer the granted angle to the unit; drive zero when nothing is granted
  always_comb begin
    cordic_theta = 32'h0;
    if (grant_0)      cordic_theta = req0_theta;
    else if (grant_1) cordic_theta = req1_theta;
  end

  // Round-robin pointer moves only when a grant actually happens
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     last_grant <= 1'b1;
    else if (grant_0) last_grant <= 1'b0;
    else if (grant_1) last_grant <= 1'b1;
  end

  // Valid/id shift register mirroring the unit's pipeline
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      trk_valid <= '0;
      trk_id    <= '0;
    end else begin
      trk_valid <= {trk_valid[DEPTH-2:0], accept};
      trk_id    <= {trk_id[DEPTH-2:0], grant_1};
    end
  end

  // Tag shift register travelling alongside the valid/id bits
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) trk_tag[i] <= '0;
    end else begin
      trk_tag[0] <= grant_1 ? req1_tag : req0_tag;
      for (int i = 1; i < DEPTH; i++) trk_tag[i] <= trk_tag[i-1];
    end
  end

  // Capture the unit's result into the owning requester's response port
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp0_valid  <= 1'b0;
      rsp0_result <= 32'h0;
      rsp0_tag    <= '0;
      rsp1_valid  <= 1'b0;
      rsp1_result <= 32'h0;
      rsp1_tag    <= '0;
    end else begin
      rsp0_valid <= trk_valid[DEPTH-1] && !trk_id[DEPTH-1];
      rsp1_valid <= trk_valid[DEPTH-1] &&  trk_id[DEPTH-1];
      if (trk_valid[DEPTH-1] && !trk_id[DEPTH-1]) begin
        rsp0_result <= cordic_result;
        rsp0_tag    <= trk_tag[DEPTH-1];
      end
      if (trk_valid[DEPTH-1] && trk_id[DEPTH-1]) begin
        rsp1_result <= cordic_result;
        rsp1_tag    <= trk_tag[DEPTH-1];
      end
    end
  end

  // Outstanding counters: count up on accept, down on the response pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_cnt_0 <= '0;
      out_cnt_1 <= '0;
    end else begin
      case ({grant_0, rsp0_valid})
        2'b10:   out_cnt_0 <= out_cnt_0 + CNT_ONE;
        2'b01:   out_cnt_0 <= out_cnt_0 - CNT_ONE;
        default: out_cnt_0 <= out_cnt_0;
      endcase
      case ({grant_1, rsp1_valid})
        2'b10:   out_cnt_1 <= out_cnt_1 + CNT_ONE;
        2'b01:   out_cnt_1 <= out_cnt_1 - CNT_ONE;
        default: out_cnt_1 <= out_cnt_1;
      endcase
    end
  end

  assign busy = (|trk_valid) | rsp0_valid | rsp1_valid;

endmodule

// File: tb/tb_cordic_arbiter.sv
// Testbench for cordic_arbiter: a stand-in CORDIC unit with fixed latency,
// a queue-based reference model of arbitration and response timing, a
// contention vector table, hand-written corner sequences and random traffic.
module tb_cordic_arbiter;

  localparam int LATENCY = 33;
  localparam int TAG_W   = 4;
  localparam int MAX_OUT = 8;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             req0_valid, req1_valid;
  logic             req0_ready, req1_ready;
  logic [31:0]      req0_theta, req1_theta;
  logic [TAG_W-1:0] req0_tag, req1_tag;
  logic [31:0]      cordic_theta, cordic_result;
  logic             rsp0_valid, rsp1_valid;
  logic [31:0]      rsp0_result, rsp1_result;
  logic [TAG_W-1:0] rsp0_tag, rsp1_tag;
  logic             busy;

  always #5 clk = ~clk;

  cordic_arbiter #(.LATENCY(LATENCY), .TAG_W(TAG_W), .MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_theta(req0_theta), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_theta(req1_theta), .req1_tag(req1_tag),
    .cordic_theta(cordic_theta), .cordic_result(cordic_result),
    .rsp0_valid(rsp0_valid), .rsp0_result(rsp0_result), .rsp0_tag(rsp0_tag),
    .rsp1_valid(rsp1_valid), .rsp1_result(rsp1_result), .rsp1_tag(rsp1_tag),
    .busy(busy)
  );

  // Stand-in unit transform: any fixed bijection will do; maps 0.0 to 1.0
  function automatic logic [31:0] cosModel(input logic [31:0] t);
    return {t[30:0], t[31]} ^ 32'h3F80_0000;
  endfunction

  // Stand-in CORDIC unit without reset: result valid LATENCY cycles after sampling
  logic [31:0] cpipe [0:LATENCY];
  always @(posedge clk) begin
    cpipe[0] <= cosModel(cordic_theta);
    for (int i = 1; i <= LATENCY; i++) cpipe[i] <= cpipe[i-1];
  end
  assign cordic_result = cpipe[LATENCY];

  int errors = 0;
  int checks = 0;

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: in-flight operations as a queue stamped with due edge
  typedef struct {
    int          due;
    bit          id;
    logic [3:0]  tag;
    logic [31:0] res;
  } flight_t;

  flight_t     inflight[$];
  int          cnt[2];
  bit          last;
  bit          ev[2];
  logic [31:0] er[2];
  logic [3:0]  et[2];
  int          edge_n;
  bit          gm0, gm1;

  task automatic modelReset();
    inflight.delete();
    cnt[0] = 0; cnt[1] = 0;
    last = 1'b1;
    ev[0] = 0; ev[1] = 0;
    er[0] = 0; er[1] = 0;
    et[0] = 0; et[1] = 0;
    edge_n = 0;
  endtask

  task automatic checkOutput();
    bit e0, e1;
    logic [31:0] exp_theta;
    e0 = req0_valid && cnt[0] < MAX_OUT;
    e1 = req1_valid && cnt[1] < MAX_OUT;
    gm0 = e0 && (!e1 || last);
    gm1 = e1 && (!e0 || !last);
    exp_theta = gm0 ? req0_theta : (gm1 ? req1_theta : 32'h0);
    compare("req0_ready", 32'(req0_ready), 32'(gm0));
    compare("req1_ready", 32'(req1_ready), 32'(gm1));
    compare("cordic_theta", cordic_theta, exp_theta);
    compare("rsp0_valid", 32'(rsp0_valid), 32'(ev[0]));
    compare("rsp1_valid", 32'(rsp1_valid), 32'(ev[1]));
    compare("rsp0_result", rsp0_result, er[0]);
    compare("rsp1_result", rsp1_result, er[1]);
    compare("rsp0_tag", 32'(rsp0_tag), 32'(et[0]));
    compare("rsp1_tag", 32'(rsp1_tag), 32'(et[1]));
    compare("busy", 32'(busy), 32'(inflight.size() > 0 || ev[0] || ev[1]));
  endtask

  // Advance the model across the coming clock edge
  task automatic modelStep();
    flight_t f;
    edge_n++;
    cnt[0] = cnt[0] + int'(gm0) - int'(ev[0]);
    cnt[1] = cnt[1] + int'(gm1) - int'(ev[1]);
    ev[0] = 0; ev[1] = 0;
    if (inflight.size() > 0 && inflight[0].due == edge_n) begin
      f = inflight.pop_front();
      ev[f.id] = 1;
      er[f.id] = f.res;
      et[f.id] = f.tag;
    end
    if (gm0 || gm1) begin
      f.due = edge_n + LATENCY + 1;
      f.id  = gm1;
      f.tag = gm1 ? req1_tag : req0_tag;
      f.res = cosModel(gm1 ? req1_theta : req0_theta);
      inflight.push_back(f);
      last = gm1;
    end
  endtask

  task automatic applyStimulus(input bit v0, input bit v1, input logic [31:0] t0,
                               input logic [31:0] t1, input logic [3:0] g0, input logic [3:0] g1);
    @(negedge clk);
    req0_valid = v0; req1_valid = v1;
    req0_theta = t0; req1_theta = t1;
    req0_tag   = g0; req1_tag   = g1;
    #1;
    checkOutput();
    modelStep();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 32'h0, 32'h0, 4'h0, 4'h0);
  endtask

  // Mid-cycle asynchronous reset: outputs must clear without waiting for a clock
  task automatic doReset();
    @(negedge clk);
    req0_valid = 0; req1_valid = 0;
    #2 reset_n = 1'b0;
    #1;
    compare("rst rsp0_valid", 32'(rsp0_valid), 32'h0);
    compare("rst rsp1_valid", 32'(rsp1_valid), 32'h0);
    compare("rst rsp0_result", rsp0_result, 32'h0);
    compare("rst rsp1_result", rsp1_result, 32'h0);
    compare("rst rsp0_tag", 32'(rsp0_tag), 32'h0);
    compare("rst rsp1_tag", 32'(rsp1_tag), 32'h0);
    compare("rst busy", 32'(busy), 32'h0);
    modelReset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  typedef struct {
    bit          v0, v1;
    logic [31:0] t0, t1;
    logic [3:0]  g0, g1;
    bit          r0, r1;
    logic [31:0] th;
  } vec_t;

  vec_t tbl[13];

  function automatic vec_t mkVec(input bit v0, input bit v1, input bit r0, input bit r1, input int i);
    vec_t v;
    v.v0 = v0; v.v1 = v1; v.r0 = r0; v.r1 = r1;
    v.t0 = 32'h4000_0000 + 32'(i);
    v.t1 = 32'hC000_0000 + 32'(i);
    v.g0 = 4'(i);
    v.g1 = 4'(15 - i);
    v.th = r0 ? v.t0 : (r1 ? v.t1 : 32'h0);
    return v;
  endfunction

  initial begin
    int k, accepts, pulses;
    bit seen;

    // Contention from reset: pointer starts at 1, so requester 0 wins first
    tbl[0]  = mkVec(1, 1, 1, 0, 0);
    tbl[1]  = mkVec(1, 1, 0, 1, 1);
    tbl[2]  = mkVec(1, 1, 1, 0, 2);
    tbl[3]  = mkVec(1, 1, 0, 1, 3);
    tbl[4]  = mkVec(1, 0, 1, 0, 4);
    tbl[5]  = mkVec(1, 1, 0, 1, 5);
    tbl[6]  = mkVec(0, 1, 0, 1, 6);
    tbl[7]  = mkVec(1, 1, 1, 0, 7);
    tbl[8]  = mkVec(0, 0, 0, 0, 8);
    tbl[9]  = mkVec(1, 1, 0, 1, 9);
    tbl[10] = mkVec(1, 0, 1, 0, 10);
    tbl[11] = mkVec(0, 1, 0, 1, 11);
    tbl[12] = mkVec(1, 1, 1, 0, 12);

    reset_n = 1'b0;
    req0_valid = 0; req1_valid = 0;
    req0_theta = 0; req1_theta = 0;
    req0_tag = 0;   req1_tag = 0;
    modelReset();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    $display("[TB] idle after reset");
    idle(5);

    $display("[TB] single request");
    applyStimulus(1, 0, 32'h0, 32'h0, 4'd3, 4'd0);
    compare("single ready0", 32'(req0_ready), 32'h1);
    seen = 0; pulses = 0;
    for (k = 1; k <= 40; k++) begin
      applyStimulus(0, 0, 32'h0, 32'h0, 4'h0, 4'h0);
      if (rsp1_valid) pulses++;
      if (rsp0_valid && !seen) begin
        seen = 1;
        compare("single latency", 32'(k - 1), 32'd34);
        compare("single result", rsp0_result, 32'h3F80_0000);
        compare("single tag", 32'(rsp0_tag), 32'd3);
      end
    end
    compare("single seen", 32'(seen), 32'h1);
    compare("single rsp1 pulses", 32'(pulses), 32'h0);

    $display("[TB] contention table");
    doReset();
    for (int i = 0; i < 13; i++) begin
      applyStimulus(tbl[i].v0, tbl[i].v1, tbl[i].t0, tbl[i].t1, tbl[i].g0, tbl[i].g1);
      compare($sformatf("tbl[%0d] ready0", i), 32'(req0_ready), 32'(tbl[i].r0));
      compare($sformatf("tbl[%0d] ready1", i), 32'(req1_ready), 32'(tbl[i].r1));
      compare($sformatf("tbl[%0d] theta", i), cordic_theta, tbl[i].th);
    end
    idle(40);

    $display("[TB] outstanding limit");
    accepts = 0;
    for (int i = 0; i < 80; i++) begin
      applyStimulus(1, 0, $urandom, 32'h0, 4'(i), 4'h0);
      if (i < 20 && req0_ready) accepts++;
    end
    compare("limit accepts in 20", 32'(accepts), 32'd8);
    idle(40);

    $display("[TB] reset mid-flight");
    for (int i = 0; i < 5; i++) applyStimulus(1, 0, 32'h1000_0000 + 32'(i), 32'h0, 4'(i + 7), 4'h0);
    idle(10);
    doReset();
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      applyStimulus(0, 0, 32'h0, 32'h0, 4'h0, 4'h0);
      if (rsp0_valid || rsp1_valid) pulses++;
    end
    compare("post-reset stale pulses", 32'(pulses), 32'h0);
    applyStimulus(1, 1, 32'h2222_0000, 32'h3333_0000, 4'd5, 4'd6);
    compare("post-reset ready0", 32'(req0_ready), 32'h1);
    compare("post-reset ready1", 32'(req1_ready), 32'h0);
    idle(40);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++)
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                    $urandom, $urandom, 4'($urandom), 4'($urandom));
    idle(45);
    compare("final busy", 32'(busy), 32'h0);
    compare("final theta", cordic_theta, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
